// File: rtl/rotr_pkg.sv
// Shared types and constants for the iterative rotate-right unit.
package rotr_pkg;

    // Default datapath geometry; CNT_W is log2(WIDTH) and also the BUSY cycle count.
    localparam int unsigned ROTR_WIDTH = 16;
    localparam int unsigned ROTR_CNT_W = 4;

    // Control FSM states; 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ROTR_IDLE = 2'b00,
        ROTR_BUSY = 2'b01,
        ROTR_DONE = 2'b10
    } rotr_state_e;

    // Width of the stage index k, which counts 0..cnt_w-1 (at least 1 bit).
    function automatic int unsigned rotr_k_w(input int unsigned cnt_w);
        return (cnt_w > 1) ? $clog2(cnt_w) : 1;
    endfunction

endpackage

// File: rtl/rotate_right_stage.sv
// One binary-weighted rotate-right stage: rotates d right by 2^k when en is set.
module rotate_right_stage
    import rotr_pkg::*;
#(
    parameter int unsigned WIDTH = ROTR_WIDTH,
    parameter int unsigned K_W   = rotr_k_w(ROTR_CNT_W)
) (
    input  logic [WIDTH-1:0] d,
    input  logic [K_W-1:0]   k,
    input  logic             en,
    output logic [WIDTH-1:0] o_rot
);

    logic [31:0]      w_amt;
    logic [WIDTH-1:0] w_rot;

    // Rotate by 2^k: bits shifted out of the LSB end re-enter at the MSB end.
    always_comb begin
        w_amt = 32'd1 << k;
        w_rot = (d >> w_amt) | (d << (WIDTH - w_amt));
        o_rot = en ? w_rot : d;
    end

endmodule

// File: rtl/rotate_right_iter.sv
// Multi-cycle rotate-right unit with valid/ready handshakes on both sides.
// One binary-weighted stage (2^k bits) is applied per clock in BUSY, so an op
// takes CNT_W BUSY cycles and the result is held in DONE until consumed.
// Optional build macro ROTR_ZERO_BYPASS_EN: an accept with Cnt==0 skips BUSY
// and goes straight to DONE with Out<=In.
module rotate_right_iter
    import rotr_pkg::*;
#(
    parameter int unsigned WIDTH = ROTR_WIDTH,
    parameter int unsigned CNT_W = ROTR_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] In,
    input  logic [CNT_W-1:0] Cnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             busy
);

    localparam int unsigned K_W = rotr_k_w(CNT_W);
    localparam logic [K_W-1:0] K_LAST = K_W'(CNT_W - 1);

    rotr_state_e      r_state;
    rotr_state_e      w_state_next;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [K_W-1:0]   r_k;
    logic [K_W-1:0]   w_k_next;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_out_next;
    logic [WIDTH-1:0] w_stage_out;
    logic             w_stage_en;

    // Only the bit of the amount selected by the current stage index matters.
    assign w_stage_en = r_cnt[r_k];

    rotate_right_stage #(
        .WIDTH (WIDTH),
        .K_W   (K_W)
    ) u_stage (
        .d     (r_acc),
        .k     (r_k),
        .en    (w_stage_en),
        .o_rot (w_stage_out)
    );

    // State and datapath registers; reset aborts any op and clears the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ROTR_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_k     <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_k     <= w_k_next;
            r_out   <= w_out_next;
        end
    end

    // Next-state and datapath update; everything holds unless a transition says otherwise.
    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_k_next     = r_k;
        w_out_next   = r_out;

        case (r_state)
            ROTR_IDLE: begin
                if (in_valid) begin
                    w_acc_next   = In;
                    w_cnt_next   = Cnt;
                    w_k_next     = '0;
                    w_state_next = ROTR_BUSY;
`ifdef ROTR_ZERO_BYPASS_EN
                    // A zero rotate needs no stages; publish the operand directly.
                    if (Cnt == '0) begin
                        w_out_next   = In;
                        w_state_next = ROTR_DONE;
                    end
`endif
                end
            end

            ROTR_BUSY: begin
                w_acc_next = w_stage_out;
                w_k_next   = r_k + K_W'(1);
                if (r_k == K_LAST) begin
                    w_out_next   = w_stage_out;
                    w_state_next = ROTR_DONE;
                end
            end

            ROTR_DONE: begin
                if (out_ready) begin
                    w_state_next = ROTR_IDLE;
                end
            end

            default: begin
                w_state_next = ROTR_IDLE;
            end
        endcase
    end

    // Handshake outputs decode directly from the state register.
    always_comb begin
        in_ready  = (r_state == ROTR_IDLE);
        out_valid = (r_state == ROTR_DONE);
        busy      = (r_state == ROTR_BUSY) || (r_state == ROTR_DONE);
        Out       = r_out;
    end

endmodule

// File: tb/tb_rotate_right_iter.sv
// Self-checking bench for rotate_right_iter: directed cases plus random ops,
// checked against a bit-index rotate model. Works for either build of
// ROTR_ZERO_BYPASS_EN.
module tb_rotate_right_iter;

    localparam int W  = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [CW-1:0] cnt;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rotate_right_iter #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .In        (in_data),
        .Cnt       (cnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Out       (out_data),
        .busy      (busy)
    );

    // Result bit i comes from operand bit (i+n) mod W.
    function automatic logic [W-1:0] model_rotr(input logic [W-1:0] x, input int n);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = x[(i + n) % W];
        return r;
    endfunction

    function automatic int exp_latency(input int c);
`ifdef ROTR_ZERO_BYPASS_EN
        if (c == 0) return 1;
`endif
        return CW + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op and let it be accepted at the next edge.
    task automatic accept(input string tag, input logic [W-1:0] a, input logic [CW-1:0] c);
        int guard = 0;
        while (in_ready !== 1'b1 && guard < 64) begin
            tick();
            guard++;
        end
        check({tag, " ready_wait"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = a;
        cnt      = c;
        tick();
        in_valid = 1'b0;
    endtask

    // Called right after the accept edge; measures latency in edges from accept.
    task automatic wait_result(input string tag, input logic [W-1:0] exp_out, input int exp_lat);
        int lat = 1;
        bit ready_seen = 1'b0;
        bit busy_low = 1'b0;
        while (out_valid !== 1'b1 && lat < 64) begin
            if (in_ready !== 1'b0) ready_seen = 1'b1;
            if (busy !== 1'b1) busy_low = 1'b1;
            tick();
            lat++;
        end
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " Out"}, 32'(out_data), 32'(exp_out));
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " in_ready_low_busy"}, 32'(ready_seen), 32'd0);
        check({tag, " busy_high"}, 32'(busy_low), 32'd0);
        check({tag, " in_ready_low_done"}, 32'(in_ready), 32'd0);
    endtask

    // Hold off the consumer for some cycles, then complete the output handshake.
    task automatic finish_op(input string tag, input int hold, input logic [W-1:0] held);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            tick();
            check({tag, " hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold_Out"}, 32'(out_data), 32'(held));
            check({tag, " hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " post_valid"}, 32'(out_valid), 32'd0);
        check({tag, " post_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " post_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [CW-1:0] c,
                          input int hold);
        accept(tag, a, c);
        wait_result(tag, model_rotr(a, int'(c)), exp_latency(int'(c)));
        finish_op(tag, hold, model_rotr(a, int'(c)));
    endtask

    initial begin
        logic [W-1:0] one;
        logic [W-1:0] ra;
        logic [CW-1:0] rc;
        one       = 16'h0001;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        cnt       = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset Out", 32'(out_data), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);

        // Directed: known-answer values.
        accept("t1", 16'h8001, 4'd1);
        wait_result("t1", 16'hC000, 5);
        finish_op("t1", 0, 16'hC000);

        run_op("t2a", 16'h1234, 4'd4, 0);
        check("t2a const", 32'(model_rotr(16'h1234, 4)), 32'h4123);
        run_op("t2b", 16'h1234, 4'd15, 0);
        check("t2b Out", 32'(out_data), 32'h2468);

        run_op("t3", 16'hBEEF, 4'd0, 1);
        check("t3 Out", 32'(out_data), 32'hBEEF);

        // Backpressure with a competing request that must be ignored.
        accept("t4", 16'hA5F0, 4'd8);
        wait_result("t4", 16'hF0A5, 5);
        in_valid = 1'b1;
        in_data  = 16'h1111;
        cnt      = 4'd3;
        finish_op("t4", 10, 16'hF0A5);
        accept("t4b", 16'h1111, 4'd3);
        wait_result("t4b", model_rotr(16'h1111, 3), 5);
        finish_op("t4b", 0, model_rotr(16'h1111, 3));

        // Reset in the second BUSY cycle aborts the op.
        accept("t5", 16'hFFFF, 4'd5);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5 out_valid", 32'(out_valid), 32'd0);
        check("t5 Out", 32'(out_data), 32'd0);
        check("t5 in_ready", 32'(in_ready), 32'd1);
        check("t5 busy", 32'(busy), 32'd0);
        for (int i = 0; i < 6; i++) tick();
        check("t5 no_result", 32'(out_valid), 32'd0);
        run_op("t5b", 16'h0F0F, 4'd2, 0);
        check("t5b Out", 32'(out_data), 32'hC3C3);

        // Sweep every amount on a single set bit.
        for (int c = 0; c < W; c++) begin
            run_op("t6", 16'h0001, CW'(c), 0);
            check("t6 onehot", 32'(out_data), 32'(one << ((W - c) % W)));
        end

        // Random operands, amounts and consumer stalls.
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rc = CW'($urandom_range(0, W - 1));
            run_op("rand", ra, rc, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
